ff_universal_reg: RTL

- Parametrised multi-mode register: the successor to the single-bit asynchronous-reset D/T flip-flops.
- One WIDTH-bit bank selects per cycle between hold, parallel load (D flip-flop), per-bit toggle (T flip-flop), shift left/right and up/down counting.
- Adds a synchronous clear, a serial output and a registered wrap flag.
- Used as the general storage/sequencing element in datapaths that previously chained discrete flip-flops.

---
 rtl/ff_universal_reg.sv | 98 +++++++++
 1 files changed

// File: rtl/ff_universal_reg.sv
// Multi-mode register bank: hold, load, per-bit toggle, shift left/right,
// up/down count and synchronous clear, with serial output and wrap reporting.
module ff_universal_reg #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             ser_in,
  output logic [WIDTH-1:0] Q,
  output logic             ser_out,
  output logic             tc,
  output logic             wrap
);

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD   = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD   = 3'b001;
  localparam logic [MODE_W-1:0] MODE_TOGGLE = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHL    = 3'b011;
  localparam logic [MODE_W-1:0] MODE_SHR    = 3'b100;
  localparam logic [MODE_W-1:0] MODE_UP     = 3'b101;
  localparam logic [MODE_W-1:0] MODE_DOWN   = 3'b110;
  localparam logic [MODE_W-1:0] MODE_CLEAR  = 3'b111;

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] shr_val;
  logic             q_ones;
  logic             q_zero;

  assign q_ones = &Q;
  assign q_zero = ~|Q;

  // A one-bit bank has nothing to shift through: both directions just load ser_in.
  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign shl_val = ser_in;
      assign shr_val = ser_in;
    end else begin : g_shift_wn
      assign shl_val = {Q[WIDTH-2:0], ser_in};
      assign shr_val = {ser_in, Q[WIDTH-1:1]};
    end
  endgenerate

  // Next-state selection; wrap only survives an edge that actually wrapped.
  always_comb begin
    q_next    = Q;
    wrap_next = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD:   q_next = Q;
        MODE_LOAD:   q_next = D;
        MODE_TOGGLE: q_next = Q ^ D;
        MODE_SHL:    q_next = shl_val;
        MODE_SHR:    q_next = shr_val;
        MODE_UP: begin
          q_next    = Q + WIDTH'(1);
          wrap_next = q_ones;
        end
        MODE_DOWN: begin
          q_next    = Q - WIDTH'(1);
          wrap_next = q_zero;
        end
        MODE_CLEAR:  q_next = RESET_VAL;
        default:     q_next = Q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      Q    <= RESET_VAL;
      wrap <= 1'b0;
    end else begin
      Q    <= q_next;
      wrap <= wrap_next;
    end
  end

  // Look-ahead flags derived from the current contents and selected mode.
  always_comb begin
    tc      = 1'b0;
    ser_out = 1'b0;
    if (en && (((mode == MODE_UP) && q_ones) || ((mode == MODE_DOWN) && q_zero)))
      tc = 1'b1;
    if (mode == MODE_SHL)
      ser_out = Q[WIDTH-1];
    else if (mode == MODE_SHR)
      ser_out = Q[0];
  end

endmodule
